// File: rtl/car_channel_sequencer_if.sv
// Bundle of sample-in, config, car_compute and channel-out signals for the
// CAR channel sequencer. The sequencer connects through the slave modport;
// whatever drives it (the surrounding stage or a bench) uses master.
interface car_channel_sequencer_if #(
    parameter int unsigned NUM_CHANNELS            = 8,
    parameter int unsigned CH_W                    = $clog2(NUM_CHANNELS),
    parameter int unsigned NUM_BIT_RESOLUTION_DATA = 31,
    parameter int unsigned NUM_BIT_RESOLUTION_PARA = 9
);
    // Upstream sample
    logic [NUM_BIT_RESOLUTION_DATA-1:0] x_i;
    logic                               valid_i;
    logic                               ready_o;

    // Parameter configuration and state clear
    logic                               cfg_we_i;
    logic [CH_W-1:0]                    cfg_ch_i;
    logic [NUM_BIT_RESOLUTION_PARA-1:0] cfg_a0_i;
    logic [NUM_BIT_RESOLUTION_PARA-1:0] cfg_c0_i;
    logic [NUM_BIT_RESOLUTION_PARA-1:0] cfg_r_i;
    logic [NUM_BIT_RESOLUTION_PARA-1:0] cfg_g_i;
    logic [NUM_BIT_RESOLUTION_PARA-1:0] cfg_h_i;
    logic                               clr_state_i;

    // Request to car_compute
    logic [NUM_BIT_RESOLUTION_DATA-1:0] car_z1_o;
    logic [NUM_BIT_RESOLUTION_DATA-1:0] car_z2_o;
    logic [NUM_BIT_RESOLUTION_DATA-1:0] car_x_o;
    logic [NUM_BIT_RESOLUTION_PARA-1:0] car_a0_o;
    logic [NUM_BIT_RESOLUTION_PARA-1:0] car_c0_o;
    logic [NUM_BIT_RESOLUTION_PARA-1:0] car_r_o;
    logic [NUM_BIT_RESOLUTION_PARA-1:0] car_g_o;
    logic [NUM_BIT_RESOLUTION_PARA-1:0] car_h_o;
    logic                               car_valid_o;
    logic                               car_ready_i;

    // Response from car_compute
    logic [NUM_BIT_RESOLUTION_DATA-1:0] car_z1_i;
    logic [NUM_BIT_RESOLUTION_DATA-1:0] car_z2_i;
    logic [NUM_BIT_RESOLUTION_DATA-1:0] car_y_i;
    logic                               car_valid_i;
    logic                               car_ready_o;

    // Downstream channel output
    logic [NUM_BIT_RESOLUTION_DATA-1:0] y_o;
    logic [CH_W-1:0]                    ch_o;
    logic                               last_o;
    logic                               valid_o;
    logic                               ready_i;

    modport slave (
        input  x_i, valid_i, cfg_we_i, cfg_ch_i, cfg_a0_i, cfg_c0_i, cfg_r_i, cfg_g_i, cfg_h_i,
        input  clr_state_i, car_ready_i, car_z1_i, car_z2_i, car_y_i, car_valid_i, ready_i,
        output ready_o, car_z1_o, car_z2_o, car_x_o, car_a0_o, car_c0_o, car_r_o, car_g_o,
        output car_h_o, car_valid_o, car_ready_o, y_o, ch_o, last_o, valid_o
    );

    modport master (
        output x_i, valid_i, cfg_we_i, cfg_ch_i, cfg_a0_i, cfg_c0_i, cfg_r_i, cfg_g_i, cfg_h_i,
        output clr_state_i, car_ready_i, car_z1_i, car_z2_i, car_y_i, car_valid_i, ready_i,
        input  ready_o, car_z1_o, car_z2_o, car_x_o, car_a0_o, car_c0_o, car_r_o, car_g_o,
        input  car_h_o, car_valid_o, car_ready_o, y_o, ch_o, last_o, valid_o
    );
endinterface

// File: rtl/car_channel_sequencer.sv
// CAR channel sequencer: walks one audio sample through every channel of the
// cascade, feeding car_compute with per-channel state and parameters, writing
// the updated state back and forwarding each channel's y downstream.
module car_channel_sequencer #(
    parameter int unsigned NUM_CHANNELS            = 8,
    parameter int unsigned CH_W                    = $clog2(NUM_CHANNELS),
    parameter int unsigned NUM_BIT_RESOLUTION_DATA = 31,
    parameter int unsigned NUM_BIT_RESOLUTION_PARA = 9
) (
    input logic                    clk,
    input logic                    rst_i,
    car_channel_sequencer_if.slave bus
);
    localparam int unsigned DW = NUM_BIT_RESOLUTION_DATA;
    localparam int unsigned PW = NUM_BIT_RESOLUTION_PARA;
    localparam logic [CH_W-1:0] LastCh = CH_W'(NUM_CHANNELS - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StEmit} state_e;

    state_e          state_q, state_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [DW-1:0]   cur_x_q, cur_x_d;
    logic [DW-1:0]   y_q, y_d;

    logic [DW-1:0] z1_q [NUM_CHANNELS];
    logic [DW-1:0] z1_d [NUM_CHANNELS];
    logic [DW-1:0] z2_q [NUM_CHANNELS];
    logic [DW-1:0] z2_d [NUM_CHANNELS];
    logic [PW-1:0] a0_q [NUM_CHANNELS];
    logic [PW-1:0] a0_d [NUM_CHANNELS];
    logic [PW-1:0] c0_q [NUM_CHANNELS];
    logic [PW-1:0] c0_d [NUM_CHANNELS];
    logic [PW-1:0] r_q  [NUM_CHANNELS];
    logic [PW-1:0] r_d  [NUM_CHANNELS];
    logic [PW-1:0] g_q  [NUM_CHANNELS];
    logic [PW-1:0] g_d  [NUM_CHANNELS];
    logic [PW-1:0] h_q  [NUM_CHANNELS];
    logic [PW-1:0] h_d  [NUM_CHANNELS];

    logic issue, emit;
    assign issue = (state_q == StIssue);
    assign emit  = (state_q == StEmit);

    // Next state: sample acceptance, config/clear (IDLE only), state write-back, channel step
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cur_x_d = cur_x_q;
        y_d     = y_q;
        z1_d    = z1_q;
        z2_d    = z2_q;
        a0_d    = a0_q;
        c0_d    = c0_q;
        r_d     = r_q;
        g_d     = g_q;
        h_d     = h_q;
        unique case (state_q)
            StIdle: begin
                if (bus.cfg_we_i && (32'(bus.cfg_ch_i) < NUM_CHANNELS)) begin
                    a0_d[bus.cfg_ch_i] = bus.cfg_a0_i;
                    c0_d[bus.cfg_ch_i] = bus.cfg_c0_i;
                    r_d[bus.cfg_ch_i]  = bus.cfg_r_i;
                    g_d[bus.cfg_ch_i]  = bus.cfg_g_i;
                    h_d[bus.cfg_ch_i]  = bus.cfg_h_i;
                end
                // A clear coinciding with a new sample still lands before channel 0 issues
                if (bus.clr_state_i) begin
                    for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
                        z1_d[i] = '0;
                        z2_d[i] = '0;
                    end
                end
                if (bus.valid_i) begin
                    cur_x_d = bus.x_i;
                    ch_d    = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (bus.car_ready_i) state_d = StWait;
            end
            StWait: begin
                if (bus.car_valid_i) begin
                    z1_d[ch_q] = bus.car_z1_i;
                    z2_d[ch_q] = bus.car_z2_i;
                    y_d        = bus.car_y_i;
                    // This channel's output is the next channel's input
                    cur_x_d    = bus.car_y_i;
                    state_d    = StEmit;
                end
            end
            StEmit: begin
                if (bus.ready_i) begin
                    if (ch_q == LastCh) begin
                        state_d = StIdle;
                    end else begin
                        ch_d    = ch_q + CH_W'(1);
                        state_d = StIssue;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and memory registers with synchronous clear
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= StIdle;
            ch_q    <= '0;
            cur_x_q <= '0;
            y_q     <= '0;
            z1_q    <= '{default: '0};
            z2_q    <= '{default: '0};
            a0_q    <= '{default: '0};
            c0_q    <= '{default: '0};
            r_q     <= '{default: '0};
            g_q     <= '{default: '0};
            h_q     <= '{default: '0};
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cur_x_q <= cur_x_d;
            y_q     <= y_d;
            z1_q    <= z1_d;
            z2_q    <= z2_d;
            a0_q    <= a0_d;
            c0_q    <= c0_d;
            r_q     <= r_d;
            g_q     <= g_d;
            h_q     <= h_d;
        end
    end

    // Outputs decode straight from registered state; data buses read 0 outside their phase
    assign bus.ready_o     = (state_q == StIdle);
    assign bus.car_valid_o = issue;
    assign bus.car_ready_o = (state_q == StWait);
    assign bus.car_x_o     = issue ? cur_x_q : '0;
    assign bus.car_z1_o    = issue ? z1_q[ch_q] : '0;
    assign bus.car_z2_o    = issue ? z2_q[ch_q] : '0;
    assign bus.car_a0_o    = issue ? a0_q[ch_q] : '0;
    assign bus.car_c0_o    = issue ? c0_q[ch_q] : '0;
    assign bus.car_r_o     = issue ? r_q[ch_q] : '0;
    assign bus.car_g_o     = issue ? g_q[ch_q] : '0;
    assign bus.car_h_o     = issue ? h_q[ch_q] : '0;
    assign bus.valid_o     = emit;
    assign bus.y_o         = emit ? y_q : '0;
    assign bus.ch_o        = emit ? ch_q : '0;
    assign bus.last_o      = emit && (ch_q == LastCh);
endmodule

// File: tb/tb_car_channel_sequencer.sv
// Bench for car_channel_sequencer: plays car_compute (y = x + z1, z1' = x, z2' = z1)
// and checks every issued request and emitted channel against a cascade model.
module tb_car_channel_sequencer;
    localparam int N  = 8;
    localparam int CW = 3;
    localparam int DW = 31;
    localparam int PW = 9;

    typedef struct packed {
        logic [PW-1:0] a0;
        logic [PW-1:0] c0;
        logic [PW-1:0] r;
        logic [PW-1:0] g;
        logic [PW-1:0] h;
    } par_t;

    typedef struct {
        logic [DW-1:0] x;
        logic [DW-1:0] z2_ch0;
        logic [DW-1:0] y [N];
    } vec_t;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    car_channel_sequencer_if #(
        .NUM_CHANNELS(N), .CH_W(CW), .NUM_BIT_RESOLUTION_DATA(DW), .NUM_BIT_RESOLUTION_PARA(PW)
    ) bus ();

    car_channel_sequencer #(
        .NUM_CHANNELS(N), .CH_W(CW), .NUM_BIT_RESOLUTION_DATA(DW), .NUM_BIT_RESOLUTION_PARA(PW)
    ) dut (
        .clk  (clk),
        .rst_i(rst_i),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: per-channel state and parameters
    logic [DW-1:0] m_z1 [N];
    logic [DW-1:0] m_z2 [N];
    par_t          m_par [N];

    logic [DW-1:0] got_y [N];
    logic [DW-1:0] got_z2_ch0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear_state();
        for (int i = 0; i < N; i++) begin
            m_z1[i] = '0;
            m_z2[i] = '0;
        end
    endtask

    task automatic cfg_write(input int ch, input par_t p);
        bus.cfg_we_i = 1'b1;
        bus.cfg_ch_i = CW'(ch);
        bus.cfg_a0_i = p.a0;
        bus.cfg_c0_i = p.c0;
        bus.cfg_r_i  = p.r;
        bus.cfg_g_i  = p.g;
        bus.cfg_h_i  = p.h;
        tick();
        bus.cfg_we_i = 1'b0;
        m_par[ch] = p;
    endtask

    function automatic par_t rand_par();
        return par_t'({$urandom(), $urandom()});
    endfunction

    // One sample through the whole cascade. bp < 0 picks random EMIT backpressure;
    // abort_ch >= 0 resets the DUT while that channel is in WAIT.
    task automatic run_sample(input logic [DW-1:0] x, input bit clr, input bit stall,
                              input int bp, input int abort_ch);
        logic [DW-1:0] mx, my, px, pz1;
        int t, d, lat, k;
        t = 0;
        while (!bus.ready_o && t < 50) begin tick(); t++; end
        if (!bus.ready_o) begin timeout("wait_ready_o"); return; end
        bus.x_i         = x;
        bus.valid_i     = 1'b1;
        bus.clr_state_i = clr;
        tick();
        bus.valid_i     = 1'b0;
        bus.clr_state_i = 1'b0;
        check("ready_o_busy", 64'(bus.ready_o), 64'(0));
        if (clr) model_clear_state();
        mx = x;
        for (int c = 0; c < N; c++) begin
            t = 0;
            while (!bus.car_valid_o && t < 20) begin tick(); t++; end
            if (!bus.car_valid_o) begin timeout("wait_car_valid_o"); return; end
            check("car_x", 64'(bus.car_x_o), 64'(mx));
            check("car_z1", 64'(bus.car_z1_o), 64'(m_z1[c]));
            check("car_z2", 64'(bus.car_z2_o), 64'(m_z2[c]));
            check("car_params", 64'({bus.car_a0_o, bus.car_c0_o, bus.car_r_o, bus.car_g_o,
                                      bus.car_h_o}), 64'(m_par[c]));
            if (c == 0) got_z2_ch0 = bus.car_z2_o;
            px  = bus.car_x_o;
            pz1 = bus.car_z1_o;
            d = stall ? int'($urandom_range(0, 2)) : 0;
            repeat (d) tick();
            check("issue_hold_valid", 64'(bus.car_valid_o), 64'(1));
            check("issue_hold_x", 64'(bus.car_x_o), 64'(mx));
            bus.car_ready_i = 1'b1;
            tick();
            bus.car_ready_i = 1'b0;
            check("wait_car_ready_o", 64'(bus.car_ready_o), 64'(1));
            check("wait_no_car_valid", 64'(bus.car_valid_o), 64'(0));
            if (c == abort_ch) begin
                rst_i = 1'b1;
                tick();
                check("abort_ready_o", 64'(bus.ready_o), 64'(1));
                check("abort_car_ready_o", 64'(bus.car_ready_o), 64'(0));
                check("abort_valid_o", 64'(bus.valid_o), 64'(0));
                check("abort_car_valid_o", 64'(bus.car_valid_o), 64'(0));
                rst_i = 1'b0;
                model_clear_state();
                for (int i = 0; i < N; i++) m_par[i] = '0;
                return;
            end
            // Config and clear outside IDLE must be ignored
            bus.cfg_we_i    = 1'b1;
            bus.cfg_ch_i    = CW'(2);
            {bus.cfg_a0_i, bus.cfg_c0_i, bus.cfg_r_i, bus.cfg_g_i, bus.cfg_h_i} = rand_par();
            bus.clr_state_i = 1'b1;
            tick();
            bus.cfg_we_i    = 1'b0;
            bus.clr_state_i = 1'b0;
            lat = stall ? int'($urandom_range(0, 3)) : 0;
            repeat (lat) tick();
            bus.car_y_i     = px + pz1;
            bus.car_z1_i    = px;
            bus.car_z2_i    = pz1;
            bus.car_valid_i = 1'b1;
            tick();
            bus.car_valid_i = 1'b0;
            bus.car_y_i     = DW'($urandom());
            bus.car_z1_i    = DW'($urandom());
            bus.car_z2_i    = DW'($urandom());
            my      = mx + m_z1[c];
            m_z2[c] = m_z1[c];
            m_z1[c] = mx;
            check("emit_valid", 64'(bus.valid_o), 64'(1));
            check("emit_y", 64'(bus.y_o), 64'(my));
            check("emit_ch", 64'(bus.ch_o), 64'(c));
            check("emit_last", 64'(bus.last_o), 64'(c == N - 1));
            got_y[c] = bus.y_o;
            k = (bp < 0) ? int'($urandom_range(0, 3)) : bp;
            for (int j = 0; j < k; j++) begin
                tick();
                check("bp_valid", 64'(bus.valid_o), 64'(1));
                check("bp_y", 64'(bus.y_o), 64'(my));
                check("bp_ch", 64'(bus.ch_o), 64'(c));
                check("bp_no_car_valid", 64'(bus.car_valid_o), 64'(0));
            end
            bus.ready_i = 1'b1;
            tick();
            bus.ready_i = 1'b0;
            if (c < N - 1) check("next_issue", 64'(bus.car_valid_o), 64'(1));
            else           check("idle_after_last", 64'(bus.ready_o), 64'(1));
            mx = my;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [3];
        tbl[0].x = 31'h100; tbl[0].z2_ch0 = 31'h000;
        tbl[0].y = '{31'h100, 31'h100, 31'h100, 31'h100, 31'h100, 31'h100, 31'h100, 31'h100};
        tbl[1].x = 31'h085; tbl[1].z2_ch0 = 31'h000;
        tbl[1].y = '{31'h185, 31'h285, 31'h385, 31'h485, 31'h585, 31'h685, 31'h785, 31'h885};
        tbl[2].x = 31'h000; tbl[2].z2_ch0 = 31'h100;
        tbl[2].y = '{31'h085, 31'h20A, 31'h48F, 31'h814, 31'hC99, 31'h121E, 31'h18A3, 31'h2028};

        rst_i = 1'b1;
        bus.x_i = '0; bus.valid_i = 1'b0; bus.cfg_we_i = 1'b0; bus.cfg_ch_i = '0;
        bus.cfg_a0_i = '0; bus.cfg_c0_i = '0; bus.cfg_r_i = '0; bus.cfg_g_i = '0;
        bus.cfg_h_i = '0; bus.clr_state_i = 1'b0; bus.car_ready_i = 1'b0;
        bus.car_z1_i = '0; bus.car_z2_i = '0; bus.car_y_i = '0; bus.car_valid_i = 1'b0;
        bus.ready_i = 1'b0;
        model_clear_state();
        for (int i = 0; i < N; i++) m_par[i] = '0;

        tick();
        tick();
        rst_i = 1'b0;
        check("rst_ready_o", 64'(bus.ready_o), 64'(1));
        check("rst_valid_o", 64'(bus.valid_o), 64'(0));
        check("rst_car_valid_o", 64'(bus.car_valid_o), 64'(0));
        check("rst_car_ready_o", 64'(bus.car_ready_o), 64'(0));
        check("rst_y_o", 64'(bus.y_o), 64'(0));
        check("rst_last_o", 64'(bus.last_o), 64'(0));

        cfg_write(0, '{a0: 9'h0D8, c0: 9'h089, r: 9'h0F1, g: 9'h085, h: 9'h089});
        for (int i = 1; i < N; i++) cfg_write(i, rand_par());

        // Impulse, state write-back, and follow-on sample from the table
        for (int i = 0; i < 3; i++) begin
            run_sample(tbl[i].x, 1'b0, 1'b0, 0, -1);
            check("tbl_z2_ch0", 64'(got_z2_ch0), 64'(tbl[i].z2_ch0));
            for (int c = 0; c < N; c++) check("tbl_y", 64'(got_y[c]), 64'(tbl[i].y[c]));
        end

        // Five cycles of downstream backpressure on every channel
        run_sample(DW'($urandom()), 1'b0, 1'b0, 5, -1);

        // Clear together with a new sample: channel 0 sees zero state
        run_sample(31'h0123, 1'b1, 1'b1, -1, -1);

        // Reset while channel 3 waits on car_compute, then a fresh sample from channel 0
        run_sample(31'h0777, 1'b0, 1'b1, -1, 3);
        run_sample(31'h0042, 1'b0, 1'b1, -1, -1);

        // Randomized traffic with occasional reconfiguration and clears
        for (int i = 0; i < N; i++) cfg_write(i, rand_par());
        for (int s = 0; s < 12; s++) begin
            if ($urandom_range(0, 2) == 0) cfg_write(int'($urandom_range(0, N - 1)), rand_par());
            run_sample(DW'($urandom()), ($urandom_range(0, 4) == 0), 1'b1, -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
